// File: rtl/test_sequencer.sv
// Regression run controller: launches NUM_TESTS sub-benches (one by one or all together), watchdogs them
// and reports per-channel pass/fail/timeout masks. Optional macro TEST_SEQ_STOP_ON_FAIL_EN ends the run early.
module test_sequencer #(
    parameter int NUM_TESTS      = 4,
    parameter int PARALLEL       = 0,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMER_WIDTH    = 17,
    parameter int IDX_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_TESTS-1:0] sub_done,
    input  logic [NUM_TESTS-1:0] sub_error,
    output logic [NUM_TESTS-1:0] sub_start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_TESTS-1:0] pass_mask,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask,
    output logic                 first_fail_valid,
    output logic [IDX_WIDTH-1:0] first_fail_idx
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RECORD, S_FINISH} state_t;

    localparam logic [TIMER_WIDTH-1:0] TMO_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0]   IDX_LAST = IDX_WIDTH'(NUM_TESTS - 1);
    localparam logic [NUM_TESTS-1:0]   ALL_ONES = {NUM_TESTS{1'b1}};
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [NUM_TESTS-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_WIDTH'(i);
        end
        return r;
    endfunction

    state_t               state_q;
    logic [IDX_WIDTH-1:0] idx_q, ffi_q, cand_idx_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [NUM_TESTS-1:0] sub_start_q, pass_q, fail_q, tmo_q;
    logic [NUM_TESTS-1:0] res_pass_q, res_fail_q, res_tmo_q;
    logic                 busy_q, done_q, error_q, ffv_q, cand_valid_q;

    logic [NUM_TESTS-1:0] cur_mask_d, par_new_d, par_new_err_d, par_latched_d, par_tmo_d, par_fail_now_d;
    logic                 sel_done_d, sel_err_d, tmo_hit_d, par_stop_d, seq_last_d;

    // Result-capture decode for the channel under test (sequential) or all channels (parallel).
    always_comb begin
        cur_mask_d     = NUM_TESTS'(1'b1) << idx_q;
        sel_done_d     = |(sub_done & cur_mask_d);
        sel_err_d      = |(sub_error & cur_mask_d);
        tmo_hit_d      = (timer_q == TMO_LAST);
        par_new_d      = sub_done & ~(res_pass_q | res_fail_q);
        par_new_err_d  = par_new_d & sub_error;
        par_latched_d  = res_pass_q | res_fail_q | par_new_d;
        par_tmo_d      = tmo_hit_d ? ~par_latched_d : '0;
        par_fail_now_d = par_new_err_d | par_tmo_d;
        par_stop_d     = STOP_ON_FAIL && (|(res_fail_q | par_new_err_d));
        seq_last_d     = (idx_q == IDX_LAST) || (STOP_ON_FAIL && cand_valid_q);
    end

    // Run-sequence FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            sub_start_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            tmo_q        <= '0;
            ffv_q        <= 1'b0;
            ffi_q        <= '0;
            res_pass_q   <= '0;
            res_fail_q   <= '0;
            res_tmo_q    <= '0;
            cand_valid_q <= 1'b0;
            cand_idx_q   <= '0;
        end else begin
            sub_start_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LAUNCH;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        pass_q      <= '0;
                        fail_q      <= '0;
                        tmo_q       <= '0;
                        ffv_q       <= 1'b0;
                        ffi_q       <= '0;
                        idx_q       <= '0;
                        sub_start_q <= (PARALLEL != 0) ? ALL_ONES : NUM_TESTS'(1'b1);
                    end
                end
                S_LAUNCH: begin
                    timer_q      <= '0;
                    res_pass_q   <= '0;
                    res_fail_q   <= '0;
                    res_tmo_q    <= '0;
                    cand_valid_q <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (PARALLEL != 0) begin
                        // First sub_done per channel is latched; later changes are ignored.
                        res_pass_q <= res_pass_q | (par_new_d & ~sub_error);
                        res_fail_q <= res_fail_q | par_new_err_d;
                        res_tmo_q  <= par_tmo_d;
                        if (!cand_valid_q && (|par_fail_now_d)) begin
                            cand_valid_q <= 1'b1;
                            cand_idx_q   <= lowest_set(par_fail_now_d);
                        end
                        if ((par_latched_d == ALL_ONES) || tmo_hit_d || par_stop_d) begin
                            state_q <= S_RECORD;
                        end else begin
                            timer_q <= timer_q + TIMER_WIDTH'(1);
                        end
                    end else if (sel_done_d) begin
                        res_pass_q   <= sel_err_d ? '0 : cur_mask_d;
                        res_fail_q   <= sel_err_d ? cur_mask_d : '0;
                        cand_valid_q <= sel_err_d;
                        cand_idx_q   <= idx_q;
                        state_q      <= S_RECORD;
                    end else if (tmo_hit_d) begin
                        res_tmo_q    <= cur_mask_d;
                        cand_valid_q <= 1'b1;
                        cand_idx_q   <= idx_q;
                        state_q      <= S_RECORD;
                    end else begin
                        timer_q <= timer_q + TIMER_WIDTH'(1);
                    end
                end
                S_RECORD: begin
                    pass_q <= pass_q | res_pass_q;
                    fail_q <= fail_q | res_fail_q;
                    tmo_q  <= tmo_q | res_tmo_q;
                    if (!ffv_q && cand_valid_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= cand_idx_q;
                    end
                    if ((PARALLEL != 0) || seq_last_d) begin
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= |(fail_q | res_fail_q | tmo_q | res_tmo_q);
                    end else begin
                        idx_q       <= idx_q + IDX_WIDTH'(1);
                        sub_start_q <= cur_mask_d << 1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sub_start        = sub_start_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign pass_mask        = pass_q;
    assign fail_mask        = fail_q;
    assign timeout_mask     = tmo_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: one sequential and one parallel instance driven by
// behavioural sub-bench responders; expected launches and results are queued when each run is set up.
module tb_test_sequencer;

    localparam int N  = 4;
    localparam int TO = 10;

    typedef struct {
        logic [N-1:0] pass, fail, tmo;
        logic         err, ffv;
        logic [4:0]   ffi;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_go = 1'b0, p_go = 1'b0;
    logic [N-1:0] s_done, p_done, err_cfg, cfg_never;
    logic [N-1:0] s_launch, p_launch, s_pass, s_fail, s_tmo, p_pass, p_fail, p_tmo;
    logic s_busy, p_busy, s_fin, p_fin, s_error, p_error, s_ffv, p_ffv;
    logic [4:0] s_ffi, p_ffi;

    int cfg_delay[N];
    int s_cnt[N], p_cnt[N];
    int s_pulse_cyc[N];
    int cyc = 0, done_cyc = 0;
    int checks = 0, errors = 0;
    logic [N-1:0] s_lq[$], p_lq[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    test_sequencer #(.NUM_TESTS(N), .PARALLEL(0), .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(17), .IDX_WIDTH(5)) u_seq (
        .clk(clk), .reset(reset), .start(s_go), .sub_done(s_done), .sub_error(err_cfg),
        .sub_start(s_launch), .busy(s_busy), .done(s_fin), .error(s_error),
        .pass_mask(s_pass), .fail_mask(s_fail), .timeout_mask(s_tmo),
        .first_fail_valid(s_ffv), .first_fail_idx(s_ffi));

    test_sequencer #(.NUM_TESTS(N), .PARALLEL(1), .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(17), .IDX_WIDTH(5)) u_par (
        .clk(clk), .reset(reset), .start(p_go), .sub_done(p_done), .sub_error(err_cfg),
        .sub_start(p_launch), .busy(p_busy), .done(p_fin), .error(p_error),
        .pass_mask(p_pass), .fail_mask(p_fail), .timeout_mask(p_tmo),
        .first_fail_valid(p_ffv), .first_fail_idx(p_ffi));

    always @(posedge clk) cyc <= cyc + 1;

    // Sub-bench responders: done rises cfg_delay cycles after the launch pulse, cleared by a new launch.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                s_cnt[i] <= 0; s_done[i] <= 1'b0;
                p_cnt[i] <= 0; p_done[i] <= 1'b0;
            end else begin
                if (s_launch[i]) begin
                    s_cnt[i]  <= 1;
                    s_done[i] <= !cfg_never[i] && (cfg_delay[i] == 1);
                end else if (s_cnt[i] != 0) begin
                    s_cnt[i] <= s_cnt[i] + 1;
                    if (!cfg_never[i] && (s_cnt[i] + 1 >= cfg_delay[i])) s_done[i] <= 1'b1;
                end
                if (p_launch[i]) begin
                    p_cnt[i]  <= 1;
                    p_done[i] <= !cfg_never[i] && (cfg_delay[i] == 1);
                end else if (p_cnt[i] != 0) begin
                    p_cnt[i] <= p_cnt[i] + 1;
                    if (!cfg_never[i] && (p_cnt[i] + 1 >= cfg_delay[i])) p_done[i] <= 1'b1;
                end
            end
        end
    end

    // Launch scoreboard: every sub_start pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && s_launch !== '0) begin
            checks++;
            if (s_lq.size() == 0) begin
                errors++; $display("FAIL seq_launch: got %b, required no pulse", s_launch);
            end else begin
                if (s_launch !== s_lq[0]) begin
                    errors++; $display("FAIL seq_launch: got %b, required %b", s_launch, s_lq[0]);
                end
                void'(s_lq.pop_front());
            end
            for (int i = 0; i < N; i++) if (s_launch[i]) s_pulse_cyc[i] = cyc;
        end
        if (!reset && p_launch !== '0) begin
            checks++;
            if (p_lq.size() == 0) begin
                errors++; $display("FAIL par_launch: got %b, required no pulse", p_launch);
            end else begin
                if (p_launch !== p_lq[0]) begin
                    errors++; $display("FAIL par_launch: got %b, required %b", p_launch, p_lq[0]);
                end
                void'(p_lq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                           input logic [N-1:0] e, input logic [N-1:0] nv);
        cfg_delay[0] = d0; cfg_delay[1] = d1; cfg_delay[2] = d2; cfg_delay[3] = d3;
        err_cfg = e; cfg_never = nv;
    endtask

    task automatic expect_seq();
        res_t r;
        logic [N-1:0] one;
        bit ok;
        r.pass = '0; r.fail = '0; r.tmo = '0; r.err = 1'b0; r.ffv = 1'b0; r.ffi = '0;
        one = 4'b0001;
        for (int i = 0; i < N; i++) begin
            s_lq.push_back(one << i);
            ok = !cfg_never[i] && (cfg_delay[i] <= TO);
            if (ok && !err_cfg[i]) r.pass[i] = 1'b1;
            else begin
                if (ok) r.fail[i] = 1'b1; else r.tmo[i] = 1'b1;
                if (!r.ffv) begin r.ffv = 1'b1; r.ffi = 5'(i); end
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        r.err = |(r.fail | r.tmo);
        exp_q.push_back(r);
    endtask

    task automatic expect_par();
        res_t r;
        int dc[N];
        int e_cyc, maxd, best, key;
        bit all_done;
        r.pass = '0; r.fail = '0; r.tmo = '0; r.err = 1'b0; r.ffv = 1'b0; r.ffi = '0;
        maxd = 0; all_done = 1'b1; best = 1 << 30;
        for (int i = 0; i < N; i++) begin
            dc[i] = (!cfg_never[i] && cfg_delay[i] <= TO) ? cfg_delay[i] : 0;
            if (dc[i] == 0) all_done = 1'b0;
            else if (dc[i] > maxd) maxd = dc[i];
        end
        e_cyc = all_done ? maxd : TO;
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        for (int i = 0; i < N; i++) if (dc[i] != 0 && err_cfg[i] && dc[i] < e_cyc) e_cyc = dc[i];
`endif
        for (int i = 0; i < N; i++) begin
            key = 0;
            if (dc[i] != 0 && dc[i] <= e_cyc) begin
                if (err_cfg[i]) begin r.fail[i] = 1'b1; key = dc[i]; end
                else r.pass[i] = 1'b1;
            end else if (e_cyc == TO) begin
                r.tmo[i] = 1'b1; key = TO;
            end
            if (key != 0 && key < best) begin best = key; r.ffv = 1'b1; r.ffi = 5'(i); end
        end
        r.err = |(r.fail | r.tmo);
        exp_q.push_back(r);
        p_lq.push_back(4'b1111);
    endtask

    task automatic start_run(input bit par);
        @(negedge clk);
        if (par) p_go = 1'b1; else s_go = 1'b1;
        @(negedge clk);
        p_go = 1'b0; s_go = 1'b0;
    endtask

    task automatic wait_result(input bit par, input string name);
        res_t e;
        int k;
        logic fin;
        k = 0;
        fin = par ? p_fin : s_fin;
        while (!fin && k < 400) begin
            @(negedge clk); k++; fin = par ? p_fin : s_fin;
        end
        done_cyc = cyc;
        checks++;
        if (fin !== 1'b1) begin errors++; $display("FAIL %s_done: got %b after %0d cycles, required 1", name, fin, k); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_scoreboard: got empty queue, required one entry", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ((par ? p_pass : s_pass) !== e.pass) begin errors++; $display("FAIL %s_pass_mask: got %b, required %b", name, par ? p_pass : s_pass, e.pass); end
            checks++;
            if ((par ? p_fail : s_fail) !== e.fail) begin errors++; $display("FAIL %s_fail_mask: got %b, required %b", name, par ? p_fail : s_fail, e.fail); end
            checks++;
            if ((par ? p_tmo : s_tmo) !== e.tmo) begin errors++; $display("FAIL %s_timeout_mask: got %b, required %b", name, par ? p_tmo : s_tmo, e.tmo); end
            checks++;
            if ((par ? p_error : s_error) !== e.err) begin errors++; $display("FAIL %s_error: got %b, required %b", name, par ? p_error : s_error, e.err); end
            checks++;
            if ((par ? p_ffv : s_ffv) !== e.ffv) begin errors++; $display("FAIL %s_first_fail_valid: got %b, required %b", name, par ? p_ffv : s_ffv, e.ffv); end
            checks++;
            if ((par ? p_ffi : s_ffi) !== e.ffi) begin errors++; $display("FAIL %s_first_fail_idx: got %0d, required %0d", name, par ? p_ffi : s_ffi, e.ffi); end
        end
        checks++;
        if ((par ? p_busy : s_busy) !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got 1, required 0", name); end
        checks++;
        if ((par ? p_lq.size() : s_lq.size()) != 0) begin errors++; $display("FAIL %s_launch_missing: got %0d pending pulses, required 0", name, par ? p_lq.size() : s_lq.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({s_busy, s_fin, s_error, s_ffv, s_ffi, s_pass, s_fail, s_tmo, s_launch} !== '0) begin
            errors++; $display("FAIL reset_seq_outputs: got %h, required 0", {s_busy, s_fin, s_error, s_ffv, s_ffi, s_pass, s_fail, s_tmo, s_launch});
        end
        checks++;
        if ({p_busy, p_fin, p_error, p_ffv, p_ffi, p_pass, p_fail, p_tmo, p_launch} !== '0) begin
            errors++; $display("FAIL reset_par_outputs: got %h, required 0", {p_busy, p_fin, p_error, p_ffv, p_ffi, p_pass, p_fail, p_tmo, p_launch});
        end
        reset = 1'b0;
        tick(3);
        checks++;
        if ({s_busy, s_fin, s_launch} !== '0) begin
            errors++; $display("FAIL idle_after_reset: got %b, required 0", {s_busy, s_fin, s_launch});
        end
    endtask

    task automatic test_all_pass();
        set_cfg(2, 2, 2, 2, 4'b0000, 4'b0000);
        expect_seq();
        start_run(1'b0);
        checks++;
        if (s_busy !== 1'b1) begin errors++; $display("FAIL launch_busy: got %b, required 1", s_busy); end
        checks++;
        if (s_launch !== 4'b0001) begin errors++; $display("FAIL launch_first: got %b, required 0001", s_launch); end
        tick(1);
        checks++;
        if (s_launch !== 4'b0000) begin errors++; $display("FAIL launch_one_cycle: got %b, required 0000", s_launch); end
        wait_result(1'b0, "all_pass");
        checks++;
        if (done_cyc - s_pulse_cyc[3] != 4) begin errors++; $display("FAIL done_latency: got %0d, required 4", done_cyc - s_pulse_cyc[3]); end
    endtask

    task automatic test_fail_ch2();
        set_cfg(2, 2, 2, 2, 4'b0100, 4'b0000);
        expect_seq();
        start_run(1'b0);
        checks++;
        if ({s_fin, s_pass} !== 5'b0) begin errors++; $display("FAIL restart_clears: got %b, required 00000", {s_fin, s_pass}); end
        wait_result(1'b0, "fail_ch2");
    endtask

    task automatic test_timeout_ch1();
        set_cfg(2, 2, 2, 2, 4'b0000, 4'b0010);
        expect_seq();
        start_run(1'b0);
        wait_result(1'b0, "timeout_ch1");
`ifndef TEST_SEQ_STOP_ON_FAIL_EN
        checks++;
        if (s_pulse_cyc[2] - s_pulse_cyc[1] != 12) begin
            errors++; $display("FAIL timeout_spacing: got %0d, required 12", s_pulse_cyc[2] - s_pulse_cyc[1]);
        end
`endif
    endtask

    task automatic test_done_tmo_same();
        set_cfg(TO, 2, 2, 2, 4'b0000, 4'b0000);
        expect_seq();
        start_run(1'b0);
        wait_result(1'b0, "done_tmo_same");
    endtask

    task automatic test_parallel();
        set_cfg(6, 3, 4, 3, 4'b1011, 4'b0000);
        expect_par();
        start_run(1'b1);
        checks++;
        if (p_launch !== 4'b1111) begin errors++; $display("FAIL par_launch_all: got %b, required 1111", p_launch); end
        wait_result(1'b1, "par_fail");
        set_cfg(2, 3, 9, 5, 4'b0000, 4'b0100);
        expect_par();
        start_run(1'b1);
        wait_result(1'b1, "par_timeout");
    endtask

    task automatic test_reset_midrun();
        int k;
        set_cfg(2, 2, 2, 2, 4'b0000, 4'b0010);
        s_lq.push_back(4'b0001);
        s_lq.push_back(4'b0010);
        start_run(1'b0);
        k = 0;
        while (s_launch[1] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (s_launch[1] !== 1'b1) begin errors++; $display("FAIL midrun_reach_ch1: got 0 after %0d cycles, required 1", k); end
        tick(3);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({s_busy, s_fin, s_error, s_ffv, s_ffi, s_pass, s_fail, s_tmo, s_launch} !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs: got %h, required 0", {s_busy, s_fin, s_error, s_ffv, s_ffi, s_pass, s_fail, s_tmo, s_launch});
        end
        reset = 1'b0;
        tick(5);
        checks++;
        if (s_lq.size() != 0 || s_busy !== 1'b0) begin
            errors++; $display("FAIL midrun_after_reset: got pending=%0d busy=%b, required 0 and 0", s_lq.size(), s_busy);
        end
        set_cfg(2, 2, 2, 2, 4'b0000, 4'b0000);
        expect_seq();
        start_run(1'b0);
        tick(1);
        s_go = 1'b1;
        tick(1);
        s_go = 1'b0;
        wait_result(1'b0, "rerun");
        tick(6);
        checks++;
        if ({s_busy, s_fin} !== 2'b01) begin errors++; $display("FAIL start_while_busy_ignored: got busy,done=%b, required 01", {s_busy, s_fin}); end
    endtask

    initial begin
        set_cfg(2, 2, 2, 2, 4'b0000, 4'b0000);
        test_reset();
        test_all_pass();
        test_fail_ch2();
        test_timeout_ch1();
        test_done_tmo_same();
        test_parallel();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_watchdog: got no finish within 30000 cycles, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
